perceptron_param_loader: RTL
============================

Name: perceptron_param_loader

Overview:
Byte-stream writer/reader for the perceptron datapath's weight (W) and sample (X) registers, replacing hard-coded initial values.
- Accepts framed commands over a valid/ready byte interface.
- Stages writes in shadow registers and commits them atomically to active registers that drive the MAC.
- Supports readback of active registers over a second valid/ready byte interface.

Parameters:
- NUM_INPUTS, 2, number of W/X entries (1..8).
- DW, 8, entry width in bits; fixed at 8 for the byte protocol.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- in_data  input  8  command/data byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept in_data
- w_flat  output  NUM_INPUTS*8  active weights; entry i at [8i+7:8i], signed two's complement
- x_flat  output  NUM_INPUTS*8  active samples; entry i at [8i+7:8i], unsigned
- params_valid  output  1  high once any commit has occurred since reset
- commit_pulse  output  1  one-cycle pulse the cycle after active registers update
- err  output  1  sticky protocol error flag
- rd_data  output  8  readback byte
- rd_valid  output  1  rd_data valid
- rd_ready  input  1  consumer accepts rd_data

Behaviour:
- Byte transfer occurs when in_valid && in_ready on a rising clk edge. Readback transfer occurs when rd_valid && rd_ready.
- Reset (async assert, sync release):
  - shadow and active W/X = 0
  - params_valid = 0, commit_pulse = 0, err = 0
  - rd_valid = 0, rd_data = 0
  - state = IDLE, in_ready = 1
- Command byte fields:
  - [7:6] opcode: 00 WRITE_W, 01 WRITE_X, 10 COMMIT, 11 READ
  - [5:4] count-1, giving 1..4 entries
  - [3] bank select, READ only: 0 = W, 1 = X
  - [2:0] start index
- State IDLE (in_ready = 1):
  - WRITE_W / WRITE_X: latch target, index, remaining = count; go to DATA.
  - COMMIT: active <= shadow (W and X) on the same edge; params_valid <= 1; commit_pulse high next cycle; err cleared on the same edge. Stay IDLE.
  - READ: go to RDBACK.
  - Bit 3 set on a WRITE: err <= 1; data bytes are still consumed.
- State DATA (in_ready = 1):
  - Each accepted byte writes shadow[index]; index increments; remaining decrements.
  - Return to IDLE after the last byte.
  - index >= NUM_INPUTS: byte consumed and discarded, err <= 1, index still increments.
  - Active registers are unchanged until COMMIT.
- State RDBACK (in_ready = 0):
  - rd_valid asserts the cycle after entry, with rd_data = active[bank][index].
  - rd_data/rd_valid are held stable while rd_valid && !rd_ready.
  - On each transfer: advance index and decrement remaining. The next byte is presented the cycle after the transfer (rd_valid drops for one cycle between bytes).
  - After the last transfer: rd_valid = 0, return to IDLE.
  - Out-of-range index: returns 0x00 and sets err.
- The bank bit is ignored for WRITE only when 0; it is an error when 1.
- err clears only on reset or an accepted COMMIT byte. An error and a COMMIT on the same byte cannot occur; COMMIT takes precedence.
- commit_pulse is exactly one cycle per COMMIT. Back-to-back COMMITs give consecutive pulses.
- in_valid in RDBACK is ignored; no byte is consumed.
- Reset mid-frame or mid-readback: immediate return to reset state; the partial frame is lost.
- Latency: an accepted COMMIT byte updates w_flat/x_flat at the following edge output (registered); commit_pulse one cycle later.

Test Plan:
- Reset, then idle 5 cycles -> w_flat = x_flat = 0, params_valid = 0, in_ready = 1, rd_valid = 0.
- Bytes 0x10, 0x04, 0x09 (WRITE_W count 2 idx 0), then 0x50, 0x02, 0x03 (WRITE_X), then 0x80 -> before COMMIT, w_flat = 0; after COMMIT, w_flat = 0x0904, x_flat = 0x0302, params_valid = 1, single commit_pulse.
- After the above, bytes 0xD0 (READ W count 2 idx 0) with rd_ready stalled 3 cycles -> rd_data held at 0x04 during the stall, then 0x09; in_ready = 0 throughout; return to IDLE.
- WRITE_W at idx 1 with count 2 (0x11, 0xAA, 0xBB), NUM_INPUTS = 2 -> shadow W[1] = 0xAA, second byte discarded, err = 1; next COMMIT clears err and w_flat[15:8] = 0xAA.
- Bytes 0x08, 0x55 (WRITE with bank bit set) -> err = 1, byte 0x55 consumed, shadow unchanged.
- Assert rst_n low after 0x10, 0x04 (mid-frame) -> outputs return to reset values immediately; next byte 0x80 is treated as COMMIT of zeros.

Source files
------------

// File: rtl/perceptron_param_loader.sv
// Byte-stream loader for perceptron W/X registers: framed writes into shadow
// registers, atomic COMMIT to the active set, and readback of the active set.
module perceptron_param_loader #(
    parameter int NUM_INPUTS = 2,
    parameter int DW         = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_INPUTS*8-1:0] w_flat,
    output logic [NUM_INPUTS*8-1:0] x_flat,
    output logic                    params_valid,
    output logic                    commit_pulse,
    output logic                    err,
    output logic [7:0]              rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RDBACK
    } state_t;

    localparam logic [3:0] N_IDX = 4'(NUM_INPUTS);

    state_t          state;
    logic [DW-1:0]   shadow_w [NUM_INPUTS];
    logic [DW-1:0]   shadow_x [NUM_INPUTS];
    logic [DW-1:0]   active_w [NUM_INPUTS];
    logic [DW-1:0]   active_x [NUM_INPUTS];
    logic [3:0]      idx;
    logic [2:0]      remaining;
    logic            tgt_x;
    logic            bad_bank;
    logic            rd_bank;
    logic            commit_req;
    logic [DW-1:0]   rd_byte;
    logic            rd_oor;
    logic            accept;

    assign accept = in_valid && in_ready;

    always_comb begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            w_flat[8*i +: 8] = active_w[i];
            x_flat[8*i +: 8] = active_x[i];
        end
    end

    // Readback source: out-of-range indices read as zero and flag an error.
    always_comb begin
        rd_byte = '0;
        rd_oor  = 1'b1;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (idx == 4'(i)) begin
                rd_oor  = 1'b0;
                rd_byte = rd_bank ? active_x[i] : active_w[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            params_valid <= 1'b0;
            commit_pulse <= 1'b0;
            commit_req   <= 1'b0;
            err          <= 1'b0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            idx          <= '0;
            remaining    <= '0;
            tgt_x        <= 1'b0;
            bad_bank     <= 1'b0;
            rd_bank      <= 1'b0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                shadow_w[i] <= '0;
                shadow_x[i] <= '0;
                active_w[i] <= '0;
                active_x[i] <= '0;
            end
        end else begin
            // Pulse trails the active-register update by one cycle.
            commit_req   <= 1'b0;
            commit_pulse <= commit_req;
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx       <= {1'b0, in_data[2:0]};
                        remaining <= {1'b0, in_data[5:4]} + 3'd1;
                        case (in_data[7:6])
                            2'b00, 2'b01: begin
                                tgt_x    <= in_data[6];
                                bad_bank <= in_data[3];
                                if (in_data[3]) err <= 1'b1;
                                state <= DATA;
                            end
                            2'b10: begin
                                for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                                    active_w[i] <= shadow_w[i];
                                    active_x[i] <= shadow_x[i];
                                end
                                params_valid <= 1'b1;
                                commit_req   <= 1'b1;
                                err          <= 1'b0;
                            end
                            default: begin
                                rd_bank  <= in_data[3];
                                state    <= RDBACK;
                                in_ready <= 1'b0;
                            end
                        endcase
                    end
                end
                DATA: begin
                    if (accept) begin
                        // A frame with the bank bit set is drained without writing.
                        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                            if (idx == 4'(i) && !bad_bank) begin
                                if (tgt_x) shadow_x[i] <= in_data;
                                else       shadow_w[i] <= in_data;
                            end
                        end
                        if (idx >= N_IDX) err <= 1'b1;
                        idx       <= idx + 4'd1;
                        remaining <= remaining - 3'd1;
                        if (remaining == 3'd1) state <= IDLE;
                    end
                end
                RDBACK: begin
                    if (rd_valid) begin
                        if (rd_ready) begin
                            rd_valid  <= 1'b0;
                            idx       <= idx + 4'd1;
                            remaining <= remaining - 3'd1;
                            if (remaining == 3'd1) begin
                                state    <= IDLE;
                                in_ready <= 1'b1;
                            end
                        end
                    end else begin
                        rd_valid <= 1'b1;
                        rd_data  <= rd_byte;
                        if (rd_oor) err <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
